// File: rtl/mdu32.sv
// mdu32 - iterative multiply/divide unit owning the HI/LO registers.
//
// Sits after decode/register read. MULT/MULTU/DIV/DIVU run over several
// cycles (32/BITS_PER_CYCLE iterations plus one sign-fix cycle). MTHI/MTLO
// write HI/LO directly from rs when the unit is idle. MFHI/MFLO are served
// combinationally on mf_result.
//
// Handshake: an instruction is offered by holding issue=1 with Instruction
// and operands stable. It is taken on the rising edge only when stall=0;
// while stall=1 the pipeline must keep presenting the same instruction.
//
// Ports:
//   clock        system clock, rising edge
//   reset        asynchronous, active-low
//   Instruction  instruction word (opcode [31:26], funct [5:0])
//   read_data_1  rs operand
//   read_data_2  rt operand
//   issue        instruction/operands valid this cycle
//   busy         multiply/divide in progress
//   stall        MDU-class instruction offered while busy
//   hi, lo       HI/LO registers
//   mf_result    hi for MFHI, lo for MFLO, else 0
//   state_dbg    current FSM state (IDLE=0, RUN_MUL=1, RUN_DIV=2, FIX=3)
//
// Build option: define MDU_EARLY_OUT_EN to end a multiply as soon as the
// remaining multiplier bits are zero and to finish divide-by-zero at once.
module mdu32 #(
  parameter int BITS_PER_CYCLE = 1  // 1, 2 or 4
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] Instruction,
  input  logic [31:0] read_data_1,
  input  logic [31:0] read_data_2,
  input  logic        issue,
  output logic        busy,
  output logic        stall,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic [31:0] mf_result,
  output logic [1:0]  state_dbg
);
  localparam int ITER = 32 / BITS_PER_CYCLE;
  localparam logic [5:0] LAST_CNT = 6'(ITER - 1);

  localparam logic [5:0] F_MFHI = 6'b010000;
  localparam logic [5:0] F_MTHI = 6'b010001;
  localparam logic [5:0] F_MFLO = 6'b010010;
  localparam logic [5:0] F_MTLO = 6'b010011;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RUN_MUL = 2'd1,
    RUN_DIV = 2'd2,
    FIX     = 2'd3
  } state_t;

  state_t state_q, state_d;

  // ---------------- decode ----------------
  logic [5:0] funct;
  logic       is_special, is_mdu, dec_mul, dec_div, dec_signed;
  logic       dec_mthi, dec_mtlo, dec_mfhi, dec_mflo;
  logic       unused_instr;

  assign funct      = Instruction[5:0];
  assign is_special = (Instruction[31:26] == 6'b000000);
  // MDU class: funct 0100xx (move) and 0110xx (mult/div)
  assign is_mdu     = is_special && (funct[5:4] == 2'b01) && !funct[2];
  assign dec_mul    = is_special && (funct[5:1] == 5'b01100);
  assign dec_div    = is_special && (funct[5:1] == 5'b01101);
  assign dec_signed = !funct[0];  // MULT/DIV have funct[0]=0
  assign dec_mthi   = is_special && (funct == F_MTHI);
  assign dec_mtlo   = is_special && (funct == F_MTLO);
  assign dec_mfhi   = is_special && (funct == F_MFHI);
  assign dec_mflo   = is_special && (funct == F_MFLO);
  assign unused_instr = ^Instruction[25:6];

  // ---------------- datapath registers ----------------
  logic [63:0] mcand_q;   // multiplicand, shifted left each step
  logic [63:0] acc_q;     // product accumulator / remainder in [31:0]
  logic [31:0] opa_q;     // multiplier, or dividend shifting into quotient
  logic [31:0] opb_q;     // divisor magnitude
  logic [31:0] rs_raw_q;  // unmodified rs for divide-by-zero HI
  logic [5:0]  cnt_q;
  logic        sign_q, sign_r, is_div_q, div_zero_q;
  logic [31:0] hi_q, lo_q;

  logic [31:0] abs_rs, abs_rt;
  assign abs_rs = (dec_signed && read_data_1[31]) ? (~read_data_1 + 32'd1) : read_data_1;
  assign abs_rt = (dec_signed && read_data_2[31]) ? (~read_data_2 + 32'd1) : read_data_2;

  // One iteration of shift-add multiply and restoring divide.
  logic [63:0] mul_acc, mul_mcand;
  logic [31:0] mul_plier, div_quo;
  logic [32:0] div_rem;

  always_comb begin
    mul_acc   = acc_q;
    mul_mcand = mcand_q;
    mul_plier = opa_q;
    div_rem   = {1'b0, acc_q[31:0]};
    div_quo   = opa_q;
    for (int j = 0; j < BITS_PER_CYCLE; j++) begin
      if (mul_plier[0]) mul_acc = mul_acc + mul_mcand;
      mul_mcand = mul_mcand << 1;
      mul_plier = mul_plier >> 1;
      div_rem   = {div_rem[31:0], div_quo[31]};
      div_quo   = {div_quo[30:0], 1'b0};
      if (div_rem >= {1'b0, opb_q}) begin
        div_rem    = div_rem - {1'b0, opb_q};
        div_quo[0] = 1'b1;
      end
    end
  end

  // ---------------- FSM ----------------
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (issue && dec_mul) begin
          state_d = RUN_MUL;
        end else if (issue && dec_div) begin
`ifdef MDU_EARLY_OUT_EN
          state_d = (read_data_2 == 32'd0) ? FIX : RUN_DIV;
`else
          state_d = RUN_DIV;
`endif
        end
      end
      RUN_MUL: begin
`ifdef MDU_EARLY_OUT_EN
        if (cnt_q == LAST_CNT || mul_plier == 32'd0) state_d = FIX;
`else
        if (cnt_q == LAST_CNT) state_d = FIX;
`endif
      end
      RUN_DIV: if (cnt_q == LAST_CNT) state_d = FIX;
      FIX:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // ---------------- datapath ----------------
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      mcand_q    <= '0;
      acc_q      <= '0;
      opa_q      <= '0;
      opb_q      <= '0;
      rs_raw_q   <= '0;
      cnt_q      <= '0;
      sign_q     <= 1'b0;
      sign_r     <= 1'b0;
      is_div_q   <= 1'b0;
      div_zero_q <= 1'b0;
      hi_q       <= '0;
      lo_q       <= '0;
    end else begin
      case (state_q)
        IDLE: if (issue) begin
          if (dec_mthi) hi_q <= read_data_1;
          if (dec_mtlo) lo_q <= read_data_1;
          if (dec_mul || dec_div) begin
            sign_q     <= dec_signed & (read_data_1[31] ^ read_data_2[31]);
            sign_r     <= dec_signed & read_data_1[31];
            is_div_q   <= dec_div;
            div_zero_q <= (read_data_2 == 32'd0);
            rs_raw_q   <= read_data_1;
            cnt_q      <= '0;
            acc_q      <= '0;
            mcand_q    <= {32'd0, abs_rs};
            opa_q      <= dec_mul ? abs_rt : abs_rs;
            opb_q      <= abs_rt;
          end
        end
        RUN_MUL: begin
          acc_q   <= mul_acc;
          mcand_q <= mul_mcand;
          opa_q   <= mul_plier;
          cnt_q   <= cnt_q + 6'd1;
        end
        RUN_DIV: begin
          acc_q <= {32'd0, div_rem[31:0]};
          opa_q <= div_quo;
          cnt_q <= cnt_q + 6'd1;
        end
        FIX: begin
          if (is_div_q) begin
            if (div_zero_q) begin
              // Divide by zero: all-ones quotient, dividend as remainder.
              lo_q <= 32'hFFFF_FFFF;
              hi_q <= rs_raw_q;
            end else begin
              lo_q <= sign_q ? (~opa_q + 32'd1) : opa_q;
              hi_q <= sign_r ? (~acc_q[31:0] + 32'd1) : acc_q[31:0];
            end
          end else begin
            {hi_q, lo_q} <= sign_q ? (~acc_q + 64'd1) : acc_q;
          end
        end
        default: ;
      endcase
    end
  end

  // ---------------- outputs ----------------
  assign hi        = hi_q;
  assign lo        = lo_q;
  assign busy      = (state_q != IDLE);
  assign stall     = busy && issue && is_mdu;
  assign state_dbg = state_q;

  always_comb begin
    mf_result = 32'd0;
    if (dec_mfhi)      mf_result = hi_q;
    else if (dec_mflo) mf_result = lo_q;
  end
endmodule

// File: tb/tb_mdu32.sv
module tb_mdu32;
  localparam int BPC  = 1;
  localparam int ITER = 32 / BPC;

  localparam logic [5:0] F_MFHI  = 6'b010000;
  localparam logic [5:0] F_MTHI  = 6'b010001;
  localparam logic [5:0] F_MFLO  = 6'b010010;
  localparam logic [5:0] F_MTLO  = 6'b010011;
  localparam logic [5:0] F_MULT  = 6'b011000;
  localparam logic [5:0] F_MULTU = 6'b011001;
  localparam logic [5:0] F_DIV   = 6'b011010;
  localparam logic [5:0] F_DIVU  = 6'b011011;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] Instruction = 32'd0;
  logic [31:0] read_data_1 = 32'd0;
  logic [31:0] read_data_2 = 32'd0;
  logic        issue = 1'b0;
  logic        busy, stall;
  logic [31:0] hi, lo, mf_result;
  logic [1:0]  state_dbg;

  int n_cmp  = 0;
  int n_fail = 0;

  mdu32 #(.BITS_PER_CYCLE(BPC)) dut (
    .clock(clock), .reset(reset), .Instruction(Instruction),
    .read_data_1(read_data_1), .read_data_2(read_data_2), .issue(issue),
    .busy(busy), .stall(stall), .hi(hi), .lo(lo),
    .mf_result(mf_result), .state_dbg(state_dbg)
  );

  // ---------------- clock ----------------
  always #5 clock = ~clock;

  // ---------------- reference model ----------------
  // {hi, lo} from the architectural definition of each operation.
  function automatic logic [63:0] ref_result(input logic [5:0] f, input logic [31:0] a,
                                             input logic [31:0] b);
    longint sa, sb;
    logic [63:0] ua, ub;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'd0, a};
    ub = {32'd0, b};
    case (f)
      F_MULT:  return 64'(sa * sb);
      F_MULTU: return ua * ub;
      F_DIV:   if (b == 32'd0) return {a, 32'hFFFF_FFFF};
               else return {32'(sa % sb), 32'(sa / sb)};
      F_DIVU:  if (b == 32'd0) return {a, 32'hFFFF_FFFF};
               else return {32'(ua % ub), 32'(ua / ub)};
      default: return 64'd0;
    endcase
  endfunction

  // Cycles busy stays high after the accepting edge.
  function automatic int ref_latency(input logic [5:0] f, input logic [31:0] b);
    int bits, it, early;
    logic [31:0] mag;
    mag  = (f == F_MULT && b[31]) ? (32'd0 - b) : b;
    bits = 0;
    for (int i = 0; i < 32; i++) if (mag[i]) bits = i + 1;
    it = (bits + BPC - 1) / BPC;
    if (it < 1) it = 1;
    if (f == F_DIV || f == F_DIVU) early = (b == 32'd0) ? 1 : ITER + 1;
    else early = it + 1;
`ifdef MDU_EARLY_OUT_EN
    return early;
`else
    return (early > 0) ? ITER + 1 : ITER + 1;
`endif
  endfunction

  // ---------------- scoreboard ----------------
  logic [31:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] obs);
    logic [31:0] exp;
    exp = exp_q.pop_front();
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic start_op(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b);
    @(negedge clock);
    Instruction = {26'd0, f};
    read_data_1 = a;
    read_data_2 = b;
    issue       = 1'b1;
    @(negedge clock);
    issue       = 1'b0;
    Instruction = 32'd0;
  endtask

  // Counts negedges with busy high; optionally offers MDU instructions meanwhile.
  task automatic wait_idle(input bit interfere, output int n, output bit stall_bad);
    n = 0;
    stall_bad = 1'b0;
    while (busy === 1'b1 && n < 200) begin
      n++;
      if (interfere && n <= 3) begin
        Instruction = {6'd0, 20'($urandom), 2'b01, 1'($urandom), 1'b0, 2'($urandom)};
        read_data_1 = $urandom;
        read_data_2 = $urandom;
        issue       = 1'b1;
        #1;
        if (stall !== 1'b1) stall_bad = 1'b1;
      end else begin
        issue = 1'b0;
      end
      @(negedge clock);
    end
    issue       = 1'b0;
    Instruction = 32'd0;
  endtask

  task automatic do_op(input string tag, input logic [5:0] f, input logic [31:0] a,
                       input logic [31:0] b, input bit interfere);
    logic [63:0] exp;
    int n;
    bit bad;
    exp = ref_result(f, a, b);
    start_op(f, a, b);
    wait_idle(interfere, n, bad);
    exp_q.push_back(32'(ref_latency(f, b)));
    check({tag, "_latency"}, 32'(n));
    exp_q.push_back(exp[63:32]);
    check({tag, "_hi"}, hi);
    exp_q.push_back(exp[31:0]);
    check({tag, "_lo"}, lo);
    if (interfere) begin
      exp_q.push_back(32'd0);
      check({tag, "_stall_during_busy"}, {31'd0, bad});
    end
  endtask

  task automatic mt(input logic [5:0] f, input logic [31:0] v);
    @(negedge clock);
    Instruction = {26'd0, f};
    read_data_1 = v;
    issue       = 1'b1;
    @(negedge clock);
    issue       = 1'b0;
    Instruction = 32'd0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [63:0] e64;
    logic [31:0] ra, rb;
    logic [5:0]  fr;
    int n;
    bit bad;
    string tag;

    // reset state
    reset = 1'b0;
    repeat (2) @(negedge clock);
    Instruction = {26'd0, F_MFHI};
    #1;
    exp_q.push_back(32'd0); check("rst_busy", {31'd0, busy});
    exp_q.push_back(32'd0); check("rst_hi", hi);
    exp_q.push_back(32'd0); check("rst_lo", lo);
    exp_q.push_back(32'd0); check("rst_mf", mf_result);
    @(negedge clock);
    reset = 1'b1;
    Instruction = 32'd0;

    // MTHI/MTLO then reset in the middle of a divide
    mt(F_MTHI, 32'h1111_1111);
    mt(F_MTLO, 32'h2222_2222);
    exp_q.push_back(32'h1111_1111); check("mthi_pre", hi);
    exp_q.push_back(32'h2222_2222); check("mtlo_pre", lo);
    start_op(F_DIV, 32'd100, 32'd7);
    repeat (9) @(negedge clock);
    #1 reset = 1'b0;
    #1;
    exp_q.push_back(32'd0); check("midrst_busy", {31'd0, busy});
    exp_q.push_back(32'd0); check("midrst_hi", hi);
    exp_q.push_back(32'd0); check("midrst_lo", lo);
    @(negedge clock);
    reset = 1'b1;
    do_op("multu_3x5", F_MULTU, 32'd3, 32'd5, 1'b0);

    // directed arithmetic cases
    do_op("mult_m2x7", F_MULT, 32'hFFFF_FFFE, 32'd7, 1'b0);
    do_op("div_m7_2", F_DIV, 32'hFFFF_FFF9, 32'd2, 1'b0);
    do_op("divu_100_7", F_DIVU, 32'd100, 32'd7, 1'b0);
    do_op("divu_by0", F_DIVU, 32'h1234_5678, 32'd0, 1'b0);
    do_op("div_by0_neg", F_DIV, 32'h8765_4321, 32'd0, 1'b0);
    do_op("div_ovf", F_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
    do_op("mult_min_min", F_MULT, 32'h8000_0000, 32'h8000_0000, 1'b0);

    // MFLO held while busy: stalled, then sees the new LO
    e64 = ref_result(F_MULTU, 32'h0001_2345, 32'h0000_6789);
    start_op(F_MULTU, 32'h0001_2345, 32'h0000_6789);
    Instruction = {26'd0, F_MFLO};
    issue = 1'b1;
    n = 0; bad = 1'b0;
    while (busy === 1'b1 && n < 200) begin
      #1;
      if (stall !== 1'b1) bad = 1'b1;
      n++;
      @(negedge clock);
    end
    #1;
    exp_q.push_back(32'd0);        check("mflo_stalled", {31'd0, bad});
    exp_q.push_back(32'd0);        check("mflo_released", {31'd0, stall});
    exp_q.push_back(e64[31:0]);    check("mflo_value", mf_result);
    issue = 1'b0;
    Instruction = 32'd0;

    // MTHI held while busy: HI keeps the product until MTHI is accepted
    e64 = ref_result(F_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    start_op(F_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    Instruction = {26'd0, F_MTHI};
    read_data_1 = 32'hA5A5_A5A5;
    issue = 1'b1;
    n = 0;
    while (busy === 1'b1 && n < 200) begin
      n++;
      @(negedge clock);
    end
    exp_q.push_back(e64[63:32]);   check("mthi_held_hi", hi);
    @(negedge clock);
    issue = 1'b0;
    Instruction = 32'd0;
    exp_q.push_back(32'hA5A5_A5A5); check("mthi_accepted_hi", hi);

    // MTLO / MFLO in idle
    mt(F_MTLO, 32'hCAFE_BABE);
    exp_q.push_back(32'hCAFE_BABE); check("mtlo_lo", lo);
    Instruction = {26'd0, F_MFLO};
    #1;
    exp_q.push_back(32'hCAFE_BABE); check("mflo_idle", mf_result);
    Instruction = {26'd0, F_MFHI};
    #1;
    exp_q.push_back(32'hA5A5_A5A5); check("mfhi_idle", mf_result);

    // non-MDU instruction in idle is ignored
    @(negedge clock);
    Instruction = {6'b001000, 20'd0, F_MTHI};
    read_data_1 = 32'hDEAD_BEEF;
    issue = 1'b1;
    #1;
    exp_q.push_back(32'd0); check("nonmdu_mf", mf_result);
    @(negedge clock);
    issue = 1'b0;
    Instruction = 32'd0;
    exp_q.push_back(32'hA5A5_A5A5); check("nonmdu_hi", hi);
    exp_q.push_back(32'd0);         check("nonmdu_busy", {31'd0, busy});

    // non-MDU instruction while busy does not stall
    start_op(F_MULT, 32'd9, 32'hFFFF_FFFD);
    Instruction = {26'd0, 6'b100000};
    issue = 1'b1;
    #1;
    exp_q.push_back(32'd0); check("add_busy_stall", {31'd0, stall});
    Instruction = {6'b001000, 20'd0, F_MULT};
    #1;
    exp_q.push_back(32'd0); check("imm_busy_stall", {31'd0, stall});
    issue = 1'b0;
    Instruction = 32'd0;
    e64 = ref_result(F_MULT, 32'd9, 32'hFFFF_FFFD);
    wait_idle(1'b0, n, bad);
    exp_q.push_back(e64[31:0]); check("mult_9xm3_lo", lo);

    // randomized operations, some with MDU instructions offered while busy
    for (int k = 0; k < 24; k++) begin
      case ($urandom_range(0, 3))
        0: fr = F_MULT;
        1: fr = F_MULTU;
        2: fr = F_DIV;
        default: fr = F_DIVU;
      endcase
      case ($urandom_range(0, 4))
        0: begin ra = $urandom; rb = $urandom_range(0, 255); end
        1: begin ra = $urandom_range(0, 1000); rb = $urandom_range(1, 50); end
        2: begin ra = $urandom; rb = 32'd0; end
        3: begin
          ra = ($urandom_range(0, 1) != 0) ? 32'h8000_0000 : 32'hFFFF_FFFF;
          rb = ($urandom_range(0, 1) != 0) ? 32'hFFFF_FFFF : 32'd1;
        end
        default: begin ra = $urandom; rb = $urandom; end
      endcase
      tag = $sformatf("rnd%0d", k);
      do_op(tag, fr, ra, rb, 1'($urandom_range(0, 1)));
    end

    // final report
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule

// File: doc/mdu32.md
Name: mdu32

Overview:
- Iterative multiply/divide unit directly downstream of the instruction decode / register-file stage.
- Consumes the decoded instruction word and the two register read operands (rs, rt).
- Executes MULT/MULTU/DIV/DIVU over multiple cycles and owns the HI/LO registers.
- Serves MFHI/MFLO/MTHI/MTLO and raises a stall so the pipeline holds while the unit is busy.

Parameters:
- BITS_PER_CYCLE, 1: multiplier/quotient bits retired per iteration cycle. Legal values 1, 2, 4. ITER = 32/BITS_PER_CYCLE.

Ports:
- clock  in  1  single system clock; all state changes on rising edge.
- reset  in  1  asynchronous, active-low reset.
- Instruction  in  32  current instruction word; opcode [31:26], funct [5:0].
- read_data_1  in  32  rs operand from register file.
- read_data_2  in  32  rt operand from register file.
- issue  in  1  Instruction/operands valid this cycle.
- busy  out  1  mult/div in progress.
- stall  out  1  MDU-class instruction presented while busy; upstream must hold PC and Instruction.
- hi  out  32  HI register.
- lo  out  32  LO register.
- mf_result  out  32  MFHI -> hi, MFLO -> lo, else 0; combinational.

Behaviour:
- Decode: opcode 000000 with funct:
  - 010000 MFHI, 010001 MTHI, 010010 MFLO, 010011 MTLO
  - 011000 MULT, 011001 MULTU, 011010 DIV, 011011 DIVU
  - Any other instruction is ignored: no state change, stall=0.
- Reset (reset=0, asynchronous): state=IDLE, hi=0, lo=0, busy=0, stall=0, internal counters cleared. Reset mid-operation discards the operation; HI/LO read 0.
- States: IDLE -> RUN_MUL | RUN_DIV -> FIX -> IDLE.
- IDLE:
  - issue && MULT/MULTU -> capture operands, go to RUN_MUL.
  - issue && DIV/DIVU -> capture operands, go to RUN_DIV.
  - issue && MTHI -> hi<=rs at that edge. MTLO -> lo<=rs at that edge. Stay in IDLE.
- Signed ops: capture |rs| and |rt|; record sign_q = rs[31]^rt[31] and sign_r = rs[31]. Unsigned ops leave signs 0.
- RUN_MUL: shift-add, BITS_PER_CYCLE multiplier bits per cycle into a 64-bit accumulator, for ITER cycles, then go to FIX.
- RUN_DIV: restoring division, BITS_PER_CYCLE quotient bits per cycle, for ITER cycles, then go to FIX.
- FIX: apply sign correction and write HI/LO, then go to IDLE.
  - Multiply: {hi,lo} <= sign_q ? -product : product (64-bit two's complement).
  - Divide: lo <= quotient (negated if sign_q), hi <= remainder (negated if sign_r).
- Latency: issue sampled at edge E0; HI/LO written at edge E(ITER+1). BITS_PER_CYCLE=1 gives E33.
- busy: 1 from after E0 until after E(ITER+1).
- stall = busy && issue && (Instruction is any MDU-class funct), combinational. A stalled instruction is not accepted; it is re-presented and accepted in the first cycle busy=0.
- MFHI/MFLO are valid only when not stalled. In the cycle after a FIX edge, mf_result reflects the new HI/LO.
- Divide by zero (rt=0, signed or unsigned): lo=0xFFFFFFFF, hi=rs unmodified; sign fix suppressed; same latency as a normal divide.
- Signed overflow 0x80000000 / 0xFFFFFFFF: lo=0x80000000, hi=0.
- MULT/DIV issue while busy never restarts or corrupts the running operation.
- Simultaneous MTHI/MTLO issue in the FIX cycle: impossible, because stall is still 1 in that cycle.

Optional Feature:
- Macro MDU_EARLY_OUT_EN.
- Defined:
  - RUN_MUL goes to FIX as soon as the remaining unshifted multiplier bits are all zero (minimum 1 iteration).
  - RUN_DIV with divisor 0 goes to FIX after E0, i.e. result at E1, skipping the iterations.
  - Results are bit-identical to the non-early path.
- Undefined: fixed ITER+1 latency for every mult/div.

Test Plan:
- Reset low mid-RUN_DIV at cycle 10 -> busy=0 and hi=lo=0 immediately; next MULTU 3*5 gives lo=15, hi=0 at E33.
- MULT rs=0xFFFFFFFE (-2), rt=7 -> hi=0xFFFFFFFF, lo=0xFFFFFFF2 at E33; busy high exactly 33 cycles.
- DIV rs=-7 (0xFFFFFFF9), rt=2 -> lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1). DIVU rs=100, rt=7 -> lo=14, hi=2.
- DIVU rs=0x12345678, rt=0 -> lo=0xFFFFFFFF, hi=0x12345678. With MDU_EARLY_OUT_EN the result appears at E1.
- MULTU busy, then MFLO issued -> stall=1 until busy falls; mf_result then equals the new lo. MTHI issued while busy is stalled; hi is not written until accepted.
- MTLO rs=0xCAFEBABE in IDLE -> lo=0xCAFEBABE next cycle; MFLO -> mf_result=0xCAFEBABE. DIV 0x80000000 / 0xFFFFFFFF -> lo=0x80000000, hi=0.
